// File: rtl/amplitude_pkg.sv
// Shared types and the saturating amplitude update used by amplitude_bank.
package amplitude_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef enum logic {
    AMPL_OVERWRITE = 1'b0,
    AMPL_ACCUM     = 1'b1
  } acc_mode_e;

  // Wide enough that v + mu never wraps for any legal AMPL_WID/MU_LEN (< 64).
  localparam int unsigned VAL_W = 64;

  typedef struct packed {
    logic             sat;
    logic [VAL_W-1:0] val;
  } upd_t;

  function automatic upd_t ampl_update(
    input logic [VAL_W-1:0] v,
    input logic [VAL_W-1:0] mu,
    input logic             sp_in,
    input logic             sp_out,
    input logic             decay_en,
    input acc_mode_e        mode,
    input int unsigned      decay_shift,
    input int unsigned      ampl_wid
  );
    upd_t             r;
    logic [VAL_W-1:0] max_v;
    logic [VAL_W-1:0] sum;
    max_v = (VAL_W'(1) << ampl_wid) - VAL_W'(1);
    sum   = '0;
    r.val = v;
    r.sat = 1'b0;
    if (sp_in) begin
      // Load wins over a simultaneous spike-out: the old value is ignored.
      sum = (sp_out || mode == AMPL_OVERWRITE) ? mu : v + mu;
      if (sum > max_v) begin
        r.val = max_v;
        r.sat = 1'b1;
      end else begin
        r.val = sum;
      end
    end else if (sp_out) begin
      r.val = '0;
    end else if (decay_en && decay_shift != 0) begin
      r.val = v - (v >> decay_shift);
    end
    return r;
  endfunction

endpackage

// File: rtl/amplitude_bank_if.sv
// Request/response bundle between the mu source and amplitude_bank.
interface amplitude_bank_if #(
  parameter int unsigned NEURON_NO = 256,
  parameter int unsigned CH_NO     = 4,
  parameter int unsigned AMPL_WID  = 20,
  parameter int unsigned MU_LEN    = 32
);
  logic                         req_valid;
  logic                         req_ready;
  logic [$clog2(NEURON_NO)-1:0] req_addr;
  logic [$clog2(CH_NO)-1:0]     req_ch;
  logic                         sp_in;
  logic                         sp_out;
  logic                         decay_en;
  logic [MU_LEN-1:0]            mu_in;
  logic                         clear_req;
  logic                         busy;
  logic                         ampl_valid;
  logic [AMPL_WID-1:0]          ampl_out;
  logic                         sat_pulse;

  modport master (
    output req_valid, req_addr, req_ch, sp_in, sp_out, decay_en, mu_in, clear_req,
    input  req_ready, busy, ampl_valid, ampl_out, sat_pulse
  );

  modport slave (
    input  req_valid, req_addr, req_ch, sp_in, sp_out, decay_en, mu_in, clear_req,
    output req_ready, busy, ampl_valid, ampl_out, sat_pulse
  );
endinterface

// File: rtl/amplitude_ram.sv
// Simple dual-port synchronous-read RAM; a read colliding with a write returns the old word.
module amplitude_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WIDTH  = 20
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/amplitude_bank.sv
// Multi-channel amplitude store: 2-stage read-modify-write with forwarding, saturation,
// leak decay and a self-clearing sweep after reset or on clear_req.
module amplitude_bank
  import amplitude_pkg::*;
#(
  parameter int unsigned NEURON_NO   = 256,
  parameter int unsigned CH_NO       = 4,
  parameter int unsigned AMPL_WID    = 20,
  parameter int unsigned MU_LEN      = 32,
  parameter int unsigned DECAY_SHIFT = 4,
  parameter int unsigned ACC_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  amplitude_bank_if.slave  bus
);
  localparam int unsigned ADDR_W = $clog2(NEURON_NO);
  localparam int unsigned CH_W   = $clog2(CH_NO);
  localparam int unsigned IDX_W  = ADDR_W + CH_W;
  localparam acc_mode_e   MODE   = (ACC_MODE == 1) ? AMPL_ACCUM : AMPL_OVERWRITE;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               drain_q, drain_d;
  logic               req_accept;

  logic               s1_valid, s1_spi, s1_spo, s1_dec;
  logic [IDX_W-1:0]   s1_idx;
  logic [MU_LEN-1:0]  s1_mu;
  logic               s2_valid, s2_spi, s2_spo, s2_dec;
  logic [IDX_W-1:0]   s2_idx;
  logic [MU_LEN-1:0]  s2_mu;

  logic               fwd_valid;
  logic [IDX_W-1:0]   fwd_idx;
  logic [AMPL_WID-1:0] fwd_data;

  logic [AMPL_WID-1:0] rd_data, v_old, wr_data;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_en;
  upd_t               upd;

  // FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      drain_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    drain_d       = drain_q;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.clear_req) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end
      end
      DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        bus.busy  = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) state_d = IDLE;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign req_accept = bus.req_valid & bus.req_ready;

  // The request one ahead writes on the same edge this one reads, so its value comes from fwd_*.
  assign v_old = (fwd_valid && fwd_idx == s2_idx) ? fwd_data : rd_data;

  always_comb begin
    upd = ampl_update(VAL_W'(v_old), VAL_W'(s2_mu), s2_spi, s2_spo, s2_dec,
                      MODE, DECAY_SHIFT, AMPL_WID);
  end

  always_comb begin
    if (state_q == CLEAR) begin
      wr_en   = 1'b1;
      wr_idx  = clr_cnt_q;
      wr_data = '0;
    end else begin
      wr_en   = s2_valid;
      wr_idx  = s2_idx;
      wr_data = AMPL_WID'(upd.val);
    end
  end

  amplitude_ram #(
    .ADDR_W (IDX_W),
    .WIDTH  (AMPL_WID)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (wr_data),
    .rd_addr (s1_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_idx         <= '0;
      s1_spi         <= 1'b0;
      s1_spo         <= 1'b0;
      s1_dec         <= 1'b0;
      s1_mu          <= '0;
      s2_valid       <= 1'b0;
      s2_idx         <= '0;
      s2_spi         <= 1'b0;
      s2_spo         <= 1'b0;
      s2_dec         <= 1'b0;
      s2_mu          <= '0;
      fwd_valid      <= 1'b0;
      fwd_idx        <= '0;
      fwd_data       <= '0;
      bus.ampl_valid <= 1'b0;
      bus.ampl_out   <= '0;
      bus.sat_pulse  <= 1'b0;
    end else begin
      s1_valid       <= req_accept;
      s1_idx         <= {bus.req_ch, bus.req_addr};
      s1_spi         <= bus.sp_in;
      s1_spo         <= bus.sp_out;
      s1_dec         <= bus.decay_en;
      s1_mu          <= bus.mu_in;
      s2_valid       <= s1_valid;
      s2_idx         <= s1_idx;
      s2_spi         <= s1_spi;
      s2_spo         <= s1_spo;
      s2_dec         <= s1_dec;
      s2_mu          <= s1_mu;
      fwd_valid      <= s2_valid;
      fwd_idx        <= s2_idx;
      fwd_data       <= wr_data;
      bus.ampl_valid <= s2_valid;
      bus.sat_pulse  <= s2_valid & upd.sat;
      if (s2_valid) bus.ampl_out <= v_old;
    end
  end
endmodule

// File: doc/amplitude_bank.md
Name: amplitude_bank

Overview:
- Multi-channel successor to the per-neuron amplitude store, one amplitude word per (channel, neuron) pair.
- Pipelined read-modify-write: spike-in loads or accumulates, spike-out clears, optional leak decay, saturating arithmetic.
- Self-initialising clear sweep after reset or on request.
- Sits between the weight/mu source and the neuron update pipeline; returns the pre-update amplitude for each access.

Parameters:
- NEURON_NO, 256, neurons per channel (power of 2).
- CH_NO, 4, channels / synapse types (power of 2, >=2).
- AMPL_WID, 20, stored amplitude width, unsigned.
- MU_LEN, 32, mu_in width, unsigned.
- DECAY_SHIFT, 4, leak: v_next = v - (v >> DECAY_SHIFT); 0 disables leak.
- ACC_MODE, 0, 0 = spike-in overwrites, 1 = spike-in accumulates.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_addr  in  $clog2(NEURON_NO)  neuron index.
- req_ch  in  $clog2(CH_NO)  channel index.
- sp_in  in  1  spike-in: load/accumulate mu_in.
- sp_out  in  1  spike-out: clear entry.
- decay_en  in  1  apply leak when no spike.
- mu_in  in  MU_LEN  input amplitude.
- clear_req  in  1  pulse: zero the whole bank.
- busy  out  1  clear sweep active.
- ampl_valid  out  1  ampl_out valid.
- ampl_out  out  AMPL_WID  pre-update stored value of the accepted request.
- sat_pulse  out  1  the update of this request saturated.

Behaviour:
- Storage: NEURON_NO*CH_NO words, index {req_ch, req_addr}. Synchronous read. Contents are undefined until the first clear completes.
- Reset (reset=0): FSM goes to CLEAR, clear counter 0. Outputs: ampl_valid=0, ampl_out=0, sat_pulse=0, busy=1, req_ready=0. All pipeline valid bits are 0. Reset mid-sweep or mid-pipeline aborts, and the sweep restarts from 0 after release.
- FSM states:
  - CLEAR: writes 0 to one index per cycle, from 0 to NEURON_NO*CH_NO-1. busy=1, req_ready=0. After the last index goes to IDLE.
  - IDLE: req_ready=1. On clear_req goes to DRAIN. clear_req during CLEAR or DRAIN is ignored.
  - DRAIN: req_ready=0 for 2 cycles so in-flight writes retire, then goes to CLEAR.
- Pipeline:
  - Request accepted at edge N.
  - Read data available in cycle N+1, where the update is computed.
  - Write lands at edge N+2; ampl_out, ampl_valid and sat_pulse are registered at edge N+2.
  - Latency 2 cycles. Throughput 1 per cycle.
- Hazard: if a request hits the same index as the request in the write stage (back-to-back, same or different ops), the computed write value is forwarded instead of the RAM data. No stalls. Results must equal those of sequential execution.
- Update rule, in priority order on old value v:
  - sp_in & sp_out: load-wins; result as for sp_in alone, with v treated as 0.
  - sp_in: ACC_MODE=0 gives sat(mu_in); ACC_MODE=1 gives sat(v + mu_in).
  - sp_out: 0.
  - decay_en & DECAY_SHIFT != 0: v - (v >> DECAY_SHIFT). Never underflows.
  - otherwise: v (writeback of the same value is allowed).
- Saturation: result clamps to 2^AMPL_WID-1. sat_pulse=1 when clamping occurred, including mu_in > max in overwrite mode. The accumulate sum is computed MU_LEN+1 or AMPL_WID+1 bits wide, whichever is wider.
- ampl_out is always the pre-update value, after forwarding. It holds its last value when ampl_valid=0.

Decomposition:
- Package amplitude_pkg holds:
  - the state enum (IDLE, DRAIN, CLEAR);
  - the ACC_MODE encodings (AMPL_OVERWRITE=0, AMPL_ACCUM=1);
  - a function computing the saturating update from (v, mu, sp_in, sp_out, decay_en).
- Sub-module amplitude_ram: simple dual-port, synchronous-read RAM, one write port and one read port, read-old-on-collision. Forwarding lives in amplitude_bank.

Test Plan:
- Release reset → busy=1 for exactly 1024 cycles (defaults), req_ready rises at cycle 1025. A read of any entry then returns 0.
- ACC_MODE=0: sp_in to ch2/n5 with mu=0x1234, then a plain read of the same entry → second ampl_out=0x1234, sat_pulse=0. A further sp_out, then a read → 0.
- ACC_MODE=1: back-to-back sp_in to ch0/n7 with mu=0xFFFF0, then mu=0x20 → the second request's ampl_out=0xFFFF0 (forwarded) and sat_pulse=1. A subsequent read returns 0xFFFFF.
- DECAY_SHIFT=4: entry=0x100, three consecutive decay_en requests → ampl_out=0x100, 0xF0, 0xE1. Entry=0xF decays to 0xF (shift yields 0).
- sp_in & sp_out together with mu=0x55 on an entry holding 0x99 → ampl_out=0x99, stored value becomes 0x55.
- clear_req issued with two requests in flight → both complete, busy asserts 2 cycles later, all entries read 0. A reset pulse mid-sweep restarts the full 1024-cycle sweep.
